// File: rtl/de_scoreboard_multi_if.sv
// DE-stage scoreboard bus: decode request, downstream backpressure, release
// ports, redirect clear, plus the scoreboard's issue/stall/status outputs.
interface de_scoreboard_multi_if #(
   parameter int unsigned NUM_REGS  = 32,
   parameter int unsigned REGNOBITS = 5,
   parameter int unsigned NUM_SRC   = 2,
   parameter int unsigned NUM_REL   = 2
);
   logic                           de_valid;
   logic [NUM_SRC-1:0]             de_rs_en;
   logic [NUM_SRC*REGNOBITS-1:0]   de_rs_no;
   logic                           de_rd_en;
   logic [REGNOBITS-1:0]           de_rd_no;
   logic                           ds_stall;
   logic [NUM_REL-1:0]             rel_valid;
   logic [NUM_REL*REGNOBITS-1:0]   rel_no;
   logic                           sb_clear;
   logic                           de_issue;
   logic                           de_stall;
   logic [NUM_REGS-1:0]            busy_bits;
   logic                           err_underflow;
   logic [31:0]                    stall_cycles;

   modport master (
      output de_valid, de_rs_en, de_rs_no, de_rd_en, de_rd_no, ds_stall,
             rel_valid, rel_no, sb_clear,
      input  de_issue, de_stall, busy_bits, err_underflow, stall_cycles
   );

   modport slave (
      input  de_valid, de_rs_en, de_rs_no, de_rd_en, de_rd_no, ds_stall,
             rel_valid, rel_no, sb_clear,
      output de_issue, de_stall, busy_bits, err_underflow, stall_cycles
   );
endinterface

// File: rtl/de_scoreboard_multi.sv
// DE-stage register scoreboard with a saturating in-flight counter per register.
// Stalls DE on RAW hazards, counter saturation or AGEX backpressure; retires
// in-flight writes through NUM_REL release ports; clears wholesale on redirect.
module de_scoreboard_multi #(
   parameter int unsigned NUM_REGS  = 32,
   parameter int unsigned REGNOBITS = 5,
   parameter int unsigned NUM_SRC   = 2,
   parameter int unsigned NUM_REL   = 2,
   parameter int unsigned CNT_BITS  = 2,
   parameter bit          ZERO_REG  = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   de_scoreboard_multi_if.slave  sb
);
   localparam logic [CNT_BITS-1:0] CntMax = '1;

   logic [CNT_BITS-1:0] r_count [NUM_REGS];
   logic [CNT_BITS-1:0] w_count_d [NUM_REGS];
   logic                r_err_underflow;
   logic [31:0]         r_stall_cycles;
   logic                w_raw;
   logic                w_sat;
   logic                w_issue;
   logic                w_stall;
   logic                w_underflow;
   logic [REGNOBITS-1:0] w_rs;
   logic [31:0]         w_total;
   logic [31:0]         w_dec;

   // Hazard terms look only at registered counters; releases are not bypassed
   always_comb begin
      w_raw = 1'b0;
      w_rs  = '0;
      for (int s = 0; s < NUM_SRC; s++) begin
         w_rs = sb.de_rs_no[s*REGNOBITS +: REGNOBITS];
         if (sb.de_rs_en[s] && (r_count[w_rs] != '0) && !(ZERO_REG && (w_rs == '0))) begin
            w_raw = 1'b1;
         end
      end
      w_sat = sb.de_rd_en && (r_count[sb.de_rd_no] == CntMax)
              && !(ZERO_REG && (sb.de_rd_no == '0));
      // Reset gates the handshake so nothing issues while the pipe is held
      w_issue = reset && sb.de_valid && !w_raw && !w_sat && !sb.ds_stall && !sb.sb_clear;
      w_stall = reset && sb.de_valid && !w_issue;
   end

   // Per-register next count: count + issue - releases, clamped at zero on underflow
   always_comb begin
      w_underflow = 1'b0;
      w_total     = '0;
      w_dec       = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         w_dec = '0;
         for (int p = 0; p < NUM_REL; p++) begin
            if (sb.rel_valid[p] && (sb.rel_no[p*REGNOBITS +: REGNOBITS] == REGNOBITS'(i))
                && !(ZERO_REG && (i == 0))) begin
               w_dec = w_dec + 32'd1;
            end
         end
         w_total = 32'(r_count[i]);
         if (w_issue && sb.de_rd_en && (sb.de_rd_no == REGNOBITS'(i)) && !(ZERO_REG && (i == 0))) begin
            w_total = w_total + 32'd1;
         end
         if (w_dec > w_total) begin
            w_count_d[i] = '0;
            w_underflow  = 1'b1;
         end else begin
            w_count_d[i] = CNT_BITS'(w_total - w_dec);
         end
      end
   end

   // Counter and sticky underflow state; redirect clear wins over issue/release
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_REGS; i++) r_count[i] <= '0;
         r_err_underflow <= 1'b0;
      end else if (sb.sb_clear) begin
         for (int i = 0; i < NUM_REGS; i++) r_count[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) r_count[i] <= w_count_d[i];
         if (w_underflow) r_err_underflow <= 1'b1;
      end
   end

   // Free-running stall performance counter, untouched by redirect clear
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_stall_cycles <= '0;
      end else if (w_stall) begin
         r_stall_cycles <= r_stall_cycles + 32'd1;
      end
   end

   // Busy view derived purely from registered counts
   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) sb.busy_bits[i] = (r_count[i] != '0);
   end

   assign sb.de_issue      = w_issue;
   assign sb.de_stall      = w_stall;
   assign sb.err_underflow = r_err_underflow;
   assign sb.stall_cycles  = r_stall_cycles;
endmodule

// File: tb/tb_de_scoreboard_multi.sv
// Scoreboard bench for de_scoreboard_multi: directed vectors push hand-computed
// expectations; a negedge monitor pops and compares the DUT outputs.
module tb_de_scoreboard_multi;
   logic clk;
   logic reset;

   de_scoreboard_multi_if sb_if ();

   de_scoreboard_multi dut (
      .clk   (clk),
      .reset (reset),
      .sb    (sb_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          id;
      logic        issue;
      logic        stall;
      logic [31:0] busy;
      logic        err;
      logic [31:0] sc;
   } exp_t;

   exp_t        q[$];
   int          checks = 0;
   int          errors = 0;
   int          vid    = 0;
   logic [31:0] sc_exp = 0;

   task automatic chk(input string name, input int id, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s vec%0d: got %0h, expected %0h", name, id, act, req);
      end
   endtask

   // Monitor: one expectation per cycle, compared mid-cycle
   always @(negedge clk) begin
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("de_issue",      e.id, 32'(sb_if.de_issue),      32'(e.issue));
         chk("de_stall",      e.id, 32'(sb_if.de_stall),      32'(e.stall));
         chk("busy_bits",     e.id, sb_if.busy_bits,          e.busy);
         chk("err_underflow", e.id, 32'(sb_if.err_underflow), 32'(e.err));
         chk("stall_cycles",  e.id, sb_if.stall_cycles,       e.sc);
      end
   end

   task automatic vec(input logic valid, input logic [1:0] rs_en, input logic [4:0] rs0,
                      input logic [4:0] rs1, input logic rd_en, input logic [4:0] rd,
                      input logic ds, input logic [1:0] relv, input logic [4:0] rel0,
                      input logic [4:0] rel1, input logic clr, input logic rst,
                      input logic x_issue, input logic [31:0] x_busy, input logic x_err);
      exp_t e;
      @(posedge clk);
      #1;
      reset              = rst;
      sb_if.de_valid     = valid;
      sb_if.de_rs_en     = rs_en;
      sb_if.de_rs_no     = {rs1, rs0};
      sb_if.de_rd_en     = rd_en;
      sb_if.de_rd_no     = rd;
      sb_if.ds_stall     = ds;
      sb_if.rel_valid    = relv;
      sb_if.rel_no       = {rel1, rel0};
      sb_if.sb_clear     = clr;
      if (!rst) sc_exp = 0;
      e.id    = vid;
      e.issue = x_issue;
      e.stall = rst & valid & ~x_issue;
      e.busy  = x_busy;
      e.err   = x_err;
      e.sc    = sc_exp;
      q.push_back(e);
      if (rst && e.stall) sc_exp = sc_exp + 1;
      vid++;
   endtask

   initial begin
      reset           = 1'b0;
      sb_if.de_valid  = 1'b0;
      sb_if.de_rs_en  = '0;
      sb_if.de_rs_no  = '0;
      sb_if.de_rd_en  = 1'b0;
      sb_if.de_rd_no  = '0;
      sb_if.ds_stall  = 1'b0;
      sb_if.rel_valid = '0;
      sb_if.rel_no    = '0;
      sb_if.sb_clear  = 1'b0;

      //  valid rs_en rs0 rs1 rd_en rd ds relv rel0 rel1 clr rst | issue busy err
      // Held in reset: nothing issues or stalls
      vec(1, 2'b01, 5, 0, 1, 5, 0, 2'b00, 0, 0, 0, 0,   0, 32'h0,  0);
      // RAW on r5 with one-cycle release wakeup
      vec(1, 2'b00, 0, 0, 1, 5, 0, 2'b00, 0, 0, 0, 1,   1, 32'h0,  0);
      vec(1, 2'b01, 5, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1,   0, 32'h20, 0);
      vec(1, 2'b01, 5, 0, 0, 0, 0, 2'b01, 5, 0, 0, 1,   0, 32'h20, 0);
      vec(1, 2'b01, 5, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1,   1, 32'h0,  0);
      // WAW on r3 up to saturation (MAX=3)
      vec(1, 2'b00, 0, 0, 1, 3, 0, 2'b00, 0, 0, 0, 1,   1, 32'h0,  0);
      vec(1, 2'b00, 0, 0, 1, 3, 0, 2'b00, 0, 0, 0, 1,   1, 32'h8,  0);
      vec(1, 2'b00, 0, 0, 1, 3, 0, 2'b00, 0, 0, 0, 1,   1, 32'h8,  0);
      vec(1, 2'b00, 0, 0, 1, 3, 0, 2'b00, 0, 0, 0, 1,   0, 32'h8,  0);
      vec(1, 2'b00, 0, 0, 1, 3, 0, 2'b01, 3, 0, 0, 1,   0, 32'h8,  0);
      vec(1, 2'b00, 0, 0, 1, 3, 0, 2'b00, 0, 0, 0, 1,   1, 32'h8,  0);
      vec(1, 2'b00, 0, 0, 1, 3, 0, 2'b00, 0, 0, 0, 1,   0, 32'h8,  0);
      // Drain r3: 3 -2 -1 = 0
      vec(0, 2'b00, 0, 0, 0, 0, 0, 2'b11, 3, 3, 0, 1,   0, 32'h8,  0);
      vec(0, 2'b00, 0, 0, 0, 0, 0, 2'b01, 3, 0, 0, 1,   0, 32'h8,  0);
      vec(0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1,   0, 32'h0,  0);
      // r7: issue plus double release nets 1+1-2 = 0, no underflow
      vec(1, 2'b00, 0, 0, 1, 7, 0, 2'b00, 0, 0, 0, 1,   1, 32'h0,  0);
      vec(1, 2'b00, 0, 0, 1, 7, 0, 2'b11, 7, 7, 0, 1,   1, 32'h80, 0);
      vec(0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1,   0, 32'h0,  0);
      // Register 0 is never tracked
      vec(1, 2'b01, 0, 0, 1, 0, 0, 2'b00, 0, 0, 0, 1,   1, 32'h0,  0);
      vec(1, 2'b01, 0, 0, 1, 0, 0, 2'b00, 0, 0, 0, 1,   1, 32'h0,  0);
      // Release on idle r9 underflows; flag is sticky
      vec(0, 2'b00, 0, 0, 0, 0, 0, 2'b01, 9, 0, 0, 1,   0, 32'h0,  0);
      vec(0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1,   0, 32'h0,  1);
      // r4 to count 2, then redirect clear with a valid instruction
      vec(1, 2'b00, 0, 0, 1, 4, 0, 2'b00, 0, 0, 0, 1,   1, 32'h0,  1);
      vec(1, 2'b00, 0, 0, 1, 4, 0, 2'b00, 0, 0, 0, 1,   1, 32'h10, 1);
      vec(1, 2'b00, 0, 0, 1, 1, 0, 2'b00, 0, 0, 1, 1,   0, 32'h10, 1);
      vec(0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1,   0, 32'h0,  1);
      // Downstream backpressure
      vec(1, 2'b00, 0, 0, 1, 2, 1, 2'b00, 0, 0, 0, 1,   0, 32'h0,  1);
      vec(1, 2'b00, 0, 0, 1, 2, 0, 2'b00, 0, 0, 0, 1,   1, 32'h0,  1);
      // RAW through source 1, then reset dropped between edges
      vec(1, 2'b10, 0, 2, 0, 0, 0, 2'b00, 0, 0, 0, 1,   0, 32'h4,  1);
      vec(1, 2'b10, 0, 2, 0, 0, 0, 2'b00, 0, 0, 0, 0,   0, 32'h0,  0);
      vec(0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1,   0, 32'h0,  0);
      vec(1, 2'b10, 0, 2, 0, 0, 0, 2'b00, 0, 0, 0, 1,   1, 32'h0,  0);

      // Let the monitor drain, bounded
      for (int k = 0; k < 20 && q.size() > 0; k++) begin
         @(negedge clk);
         #1;
      end
      if (q.size() > 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, expected 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
